boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Parametrised program-memory boot loader between a source ROM port, the single-port program BSRAM and the cpu core.
- After reset (or on a start request), copies PROG_LEN words from the source into BSRAM while holding the CPU in reset.
- Optionally reads every word back to verify it, then releases the CPU and hands the BSRAM address port to cpu_pc.
- Successor to the ad-hoc boot sequencer; adds width/depth parameters, re-boot on request, read-back verify, error reporting and CPU reset control.

Parameters:
- ADDR_W, 11, BSRAM/source address width.
- DATA_W, 16, instruction word width.
- PROG_LEN, 16, words to load; legal range 1..2**ADDR_W.
- VERIFY, 1, 1 = read-back verify pass after load; 0 = skip.
- AUTO_BOOT, 1, 1 = boot starts out of reset; 0 = wait in IDLE for start.

Ports:
- clk_mem  in  1  memory clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to (re)boot.
- src_addr  out  ADDR_W  source ROM address.
- src_data  in  DATA_W  source ROM data, valid 1 cycle after src_addr.
- cpu_pc  in  ADDR_W  CPU fetch address.
- mem_ce  out  1  BSRAM chip enable.
- mem_wre  out  1  BSRAM write enable.
- mem_ad  out  ADDR_W  BSRAM address.
- mem_din  out  DATA_W  BSRAM write data.
- mem_dout  in  DATA_W  BSRAM read data, valid 1 cycle after mem_ad.
- cpu_rst_n  out  1  active-low CPU reset.
- busy  out  1  load or verify in progress.
- done  out  1  program loaded (and verified); CPU running.
- error  out  1  verify mismatch detected.
- err_addr  out  ADDR_W  address of first mismatch.

Behaviour:
- States: IDLE, LD_RD, LD_WR, VF_RD, VF_CMP, DONE, ERR. Registered index idx (ADDR_W bits); registered cpu_rst_n, done, error, err_addr.
- Reset values:
  - state = LD_RD if AUTO_BOOT, else IDLE.
  - idx = 0, cpu_rst_n = 0, done = 0, error = 0, err_addr = 0.
  - mem_wre = 0, mem_ce = 1.
- IDLE: start -> LD_RD, idx = 0.
- LD_RD: src_addr = idx -> LD_WR.
- LD_WR:
  - mem_ad = idx, mem_din = src_data, mem_wre = 1.
  - If idx == PROG_LEN-1: idx = 0, go to VF_RD (VERIFY=1) or DONE (VERIFY=0).
  - Else idx++ and return to LD_RD.
  - Cost: 2 cycles per word.
- VF_RD: mem_ad = idx, src_addr = idx, mem_wre = 0 -> VF_CMP.
- VF_CMP: compare mem_dout with src_data.
  - Mismatch: err_addr = idx, error = 1 -> ERR.
  - Match at last index -> DONE.
  - Otherwise idx++ -> VF_RD.
- DONE: cpu_rst_n = 1, done = 1; mem_ad = cpu_pc, mem_wre = 0.
- ERR: cpu_rst_n stays 0, error and err_addr held; mem_ad = cpu_pc, mem_wre = 0.
- Outputs:
  - busy = 1 in LD_*/VF_* states (combinational from state).
  - mem_ce is always 1.
  - mem_din and src_addr are don't-care outside their states but must not be X.
  - mem_wre is high only in LD_WR.
- Latency from reset release (AUTO_BOOT = 1) to done/cpu_rst_n high: 2·PROG_LEN cycles if VERIFY = 0, 4·PROG_LEN if VERIFY = 1.
- start rules:
  - Ignored in LD_*/VF_* states.
  - In DONE or ERR: next cycle cpu_rst_n = 0, done = 0, error = 0, idx = 0, state = LD_RD (full reload).
- PROG_LEN = 1: single LD_RD/LD_WR pair, then verify or DONE. No idx overflow; idx compare uses PROG_LEN-1.
- PROG_LEN = 2**ADDR_W: idx stops at all-ones and never wraps.
- rst_n asserted mid-load or mid-verify: immediate asynchronous return to reset values. mem_wre drops the same instant; the partial write is discarded.

Test Plan:
- AUTO_BOOT=1, VERIFY=0, PROG_LEN=14, 14-word ROM image -> exactly 14 mem_wre pulses at addresses 0..13 with matching data; done and cpu_rst_n rise after 28 clocks; then mem_ad follows cpu_pc.
- VERIFY=1, same image, BSRAM model correct -> done after 56 clocks; error = 0; busy high for 56 clocks.
- VERIFY=1, BSRAM model corrupts address 5 (bit 0 flip) -> error = 1, err_addr = 5, cpu_rst_n stays 0, done = 0.
- In DONE, pulse start with ROM changed to a new image -> cpu_rst_n low the next cycle, full reload, done again after 56 clocks, BSRAM holds the new image.
- AUTO_BOOT=0 -> stays in IDLE with no writes for 100 clocks; start pulse -> load begins; a start pulse mid-load is ignored (write count stays 14).
- Assert rst_n at word 7 of the load -> all outputs return to reset values asynchronously, mem_wre = 0; after release, reload from address 0 completes normally.

Source files
------------

// File: rtl/boot_loader.sv
// Program-memory boot loader: copies PROG_LEN words from the source ROM into
// the BSRAM with an optional read-back verify, then releases the CPU.
module boot_loader #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 16,
    parameter int PROG_LEN  = 16,
    parameter int VERIFY    = 1,
    parameter int AUTO_BOOT = 1
) (
    input  logic              clk_mem,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [ADDR_W-1:0] mem_ad,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    typedef enum logic [2:0] {
        IDLE, LD_RD, LD_WR, VF_RD, VF_CMP, DONE, ERR
    } state_t;

    localparam state_t RST_ST = (AUTO_BOOT != 0) ? LD_RD : IDLE;
    // Last index as an ADDR_W value so a full-depth image never wraps.
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;
    logic [ADDR_W-1:0] err_addr_nx;
    logic              cpu_rst_nx, done_nx, error_nx;

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_ST;
            idx       <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_addr  <= '0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            cpu_rst_n <= cpu_rst_nx;
            done      <= done_nx;
            error     <= error_nx;
            err_addr  <= err_addr_nx;
        end
    end

    assign mem_ce = 1'b1;

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        cpu_rst_nx  = cpu_rst_n;
        done_nx     = done;
        error_nx    = error;
        err_addr_nx = err_addr;
        mem_wre     = 1'b0;
        mem_ad      = idx;
        mem_din     = '0;
        src_addr    = idx;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = LD_RD;
                    idx_nx   = '0;
                end
            end
            LD_RD: begin
                busy     = 1'b1;
                state_nx = LD_WR;
            end
            LD_WR: begin
                busy    = 1'b1;
                mem_wre = 1'b1;
                mem_din = src_data;
                if (idx == LAST) begin
                    idx_nx = '0;
                    if (VERIFY != 0) begin
                        state_nx = VF_RD;
                    end else begin
                        state_nx   = DONE;
                        cpu_rst_nx = 1'b1;
                        done_nx    = 1'b1;
                    end
                end else begin
                    idx_nx   = idx + ADDR_W'(1);
                    state_nx = LD_RD;
                end
            end
            VF_RD: begin
                busy     = 1'b1;
                state_nx = VF_CMP;
            end
            VF_CMP: begin
                busy = 1'b1;
                if (mem_dout != src_data) begin
                    err_addr_nx = idx;
                    error_nx    = 1'b1;
                    state_nx    = ERR;
                end else if (idx == LAST) begin
                    state_nx   = DONE;
                    cpu_rst_nx = 1'b1;
                    done_nx    = 1'b1;
                end else begin
                    idx_nx   = idx + ADDR_W'(1);
                    state_nx = VF_RD;
                end
            end
            DONE, ERR: begin
                mem_ad = cpu_pc;
                // A start here forces a full reload with the CPU held.
                if (start) begin
                    state_nx   = LD_RD;
                    idx_nx     = '0;
                    cpu_rst_nx = 1'b0;
                    done_nx    = 1'b0;
                    error_nx   = 1'b0;
                end
            end
            default: state_nx = RST_ST;
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: three instances cover verify/auto-boot,
// idle-start without verify, and a full-depth image.
module tb_boot_loader;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk;
    int   vectors;
    int   miscompares;
    int   b_wr_cnt;
    int   c_wr_cnt;
    logic corrupt;

    logic [15:0] rom [16];
    logic [15:0] a_bram [2048];
    logic [15:0] b_bram [2048];
    logic [15:0] c_bram [4];

    chk_t        chk_q [$];
    logic [26:0] a_q [$];
    logic [26:0] b_q [$];
    logic [17:0] c_q [$];

    logic        a_rst_n, a_start, a_ce, a_wre, a_cpu, a_busy, a_done, a_error;
    logic [10:0] a_src, a_pc, a_ad, a_eaddr;
    logic [15:0] a_sdat, a_din, a_dout;

    logic        b_rst_n, b_start, b_ce, b_wre, b_cpu, b_busy, b_done, b_error;
    logic [10:0] b_src, b_pc, b_ad, b_eaddr;
    logic [15:0] b_sdat, b_din, b_dout;

    logic        c_rst_n, c_start, c_ce, c_wre, c_cpu, c_busy, c_done, c_error;
    logic [1:0]  c_src, c_pc, c_ad, c_eaddr;
    logic [15:0] c_sdat, c_din, c_dout;

    boot_loader #(.ADDR_W(11), .DATA_W(16), .PROG_LEN(14),
                  .VERIFY(1), .AUTO_BOOT(1)) u_a (
        .clk_mem(clk), .rst_n(a_rst_n), .start(a_start),
        .src_addr(a_src), .src_data(a_sdat), .cpu_pc(a_pc),
        .mem_ce(a_ce), .mem_wre(a_wre), .mem_ad(a_ad),
        .mem_din(a_din), .mem_dout(a_dout), .cpu_rst_n(a_cpu),
        .busy(a_busy), .done(a_done), .error(a_error),
        .err_addr(a_eaddr)
    );

    boot_loader #(.ADDR_W(11), .DATA_W(16), .PROG_LEN(14),
                  .VERIFY(0), .AUTO_BOOT(0)) u_b (
        .clk_mem(clk), .rst_n(b_rst_n), .start(b_start),
        .src_addr(b_src), .src_data(b_sdat), .cpu_pc(b_pc),
        .mem_ce(b_ce), .mem_wre(b_wre), .mem_ad(b_ad),
        .mem_din(b_din), .mem_dout(b_dout), .cpu_rst_n(b_cpu),
        .busy(b_busy), .done(b_done), .error(b_error),
        .err_addr(b_eaddr)
    );

    boot_loader #(.ADDR_W(2), .DATA_W(16), .PROG_LEN(4),
                  .VERIFY(1), .AUTO_BOOT(1)) u_c (
        .clk_mem(clk), .rst_n(c_rst_n), .start(c_start),
        .src_addr(c_src), .src_data(c_sdat), .cpu_pc(c_pc),
        .mem_ce(c_ce), .mem_wre(c_wre), .mem_ad(c_ad),
        .mem_din(c_din), .mem_dout(c_dout), .cpu_rst_n(c_cpu),
        .busy(c_busy), .done(c_done), .error(c_error),
        .err_addr(c_eaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM and BSRAM models, one-cycle read latency.
    always @(posedge clk) begin
        a_sdat <= rom[a_src[3:0]];
        b_sdat <= rom[b_src[3:0]];
        c_sdat <= rom[{2'b00, c_src}];
        if (a_ce) begin
            if (a_wre) a_bram[a_ad] <= a_din;
            a_dout <= a_bram[a_ad] ^ {15'd0, corrupt && a_ad == 11'd5};
        end
        if (b_ce) begin
            if (b_wre) b_bram[b_ad] <= b_din;
            b_dout <= b_bram[b_ad];
        end
        if (c_ce) begin
            if (c_wre) c_bram[c_ad] <= c_din;
            c_dout <= c_bram[c_ad];
        end
    end

    // Monitor: the only process that steps the counters.
    initial begin
        chk_t        c;
        logic [26:0] e;
        logic [17:0] ec;
        vectors = 0;
        miscompares = 0;
        b_wr_cnt = 0;
        c_wr_cnt = 0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                vectors++;
                if (c.act !== c.exp) begin
                    miscompares++;
                    $display("FAIL %s: got %0h want %0h", c.name, c.act, c.exp);
                end
            end
            if (a_wre) begin
                vectors++;
                if (a_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL a_write: unexpected ad=%0d din=%h", a_ad, a_din);
                end else begin
                    e = a_q.pop_front();
                    if ({a_ad, a_din} !== e) begin
                        miscompares++;
                        $display("FAIL a_write: got ad=%0d din=%h want ad=%0d din=%h",
                                 a_ad, a_din, e[26:16], e[15:0]);
                    end
                end
            end
            if (b_wre) begin
                b_wr_cnt++;
                vectors++;
                if (b_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL b_write: unexpected ad=%0d din=%h", b_ad, b_din);
                end else begin
                    e = b_q.pop_front();
                    if ({b_ad, b_din} !== e) begin
                        miscompares++;
                        $display("FAIL b_write: got ad=%0d din=%h want ad=%0d din=%h",
                                 b_ad, b_din, e[26:16], e[15:0]);
                    end
                end
            end
            if (c_wre) begin
                c_wr_cnt++;
                vectors++;
                if (c_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL c_write: unexpected ad=%0d din=%h", c_ad, c_din);
                end else begin
                    ec = c_q.pop_front();
                    if ({c_ad, c_din} !== ec) begin
                        miscompares++;
                        $display("FAIL c_write: got ad=%0d din=%h want ad=%0d din=%h",
                                 c_ad, c_din, ec[17:16], ec[15:0]);
                    end
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        chk_q.push_back('{n, act, exp});
    endtask

    task automatic push_a();
        for (int i = 0; i < 14; i++) a_q.push_back({11'(i), rom[i]});
    endtask

    task automatic push_b();
        for (int i = 0; i < 14; i++) b_q.push_back({11'(i), rom[i]});
    endtask

    function automatic logic fin(input int w);
        if (w == 0) return a_done | a_error;
        if (w == 1) return b_done | b_error;
        return c_done | c_error;
    endfunction

    function automatic logic bsy(input int w);
        if (w == 0) return a_busy;
        if (w == 1) return b_busy;
        return c_busy;
    endfunction

    // Counts clock edges until done or error; k = -1 on timeout.
    task automatic run(input int w, output int k, output int bc);
        k = -1;
        bc = bsy(w) ? 1 : 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk);
            #1;
            if (fin(w)) begin
                k = i;
                return;
            end
            if (bsy(w)) bc++;
        end
    endtask

    task automatic pulse(input int w);
        @(negedge clk);
        if (w == 0) a_start = 1'b1;
        else b_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    initial begin
        int k, bc;
        logic seen;
        a_rst_n = 0; b_rst_n = 0; c_rst_n = 0;
        a_start = 0; b_start = 0; c_start = 0;
        a_pc = '0; b_pc = '0; c_pc = '0;
        corrupt = 0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i * 3);
        #3;
        chk("a_rst_cpu_rst_n", 32'(a_cpu), 0);
        chk("a_rst_done", 32'(a_done), 0);
        chk("a_rst_error", 32'(a_error), 0);
        chk("a_rst_err_addr", 32'(a_eaddr), 0);
        chk("a_rst_mem_wre", 32'(a_wre), 0);
        chk("a_rst_mem_ce", 32'(a_ce), 1);

        @(negedge clk);
        a_rst_n = 1;
        push_a();
        run(0, k, bc);
        chk("a_boot_cycles", 32'(k), 56);
        chk("a_busy_cycles", 32'(bc), 56);
        chk("a_done", 32'(a_done), 1);
        chk("a_cpu_rst_n", 32'(a_cpu), 1);
        chk("a_error", 32'(a_error), 0);
        chk("a_q_left", 32'(a_q.size()), 0);
        for (int i = 0; i < 14; i++) chk("a_bram_img1", 32'(a_bram[i]), 32'(rom[i]));
        a_pc = 11'h123;
        #1;
        chk("a_mem_ad_pc", 32'(a_ad), 32'h123);
        chk("a_wre_done", 32'(a_wre), 0);

        for (int i = 0; i < 16; i++) rom[i] = 16'hC0DE ^ 16'(i * 16'h0101);
        pulse(0);
        chk("a_reboot_cpu_rst_n", 32'(a_cpu), 0);
        chk("a_reboot_done", 32'(a_done), 0);
        push_a();
        run(0, k, bc);
        chk("a_reboot_cycles", 32'(k), 56);
        chk("a_reboot_done2", 32'(a_done), 1);
        for (int i = 0; i < 14; i++) chk("a_bram_img2", 32'(a_bram[i]), 32'(rom[i]));

        corrupt = 1;
        pulse(0);
        push_a();
        run(0, k, bc);
        chk("a_err_cycles", 32'(k), 40);
        chk("a_err_error", 32'(a_error), 1);
        chk("a_err_addr", 32'(a_eaddr), 5);
        chk("a_err_cpu_rst_n", 32'(a_cpu), 0);
        chk("a_err_done", 32'(a_done), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("a_err_hold_error", 32'(a_error), 1);
        chk("a_err_hold_cpu", 32'(a_cpu), 0);
        chk("a_err_hold_addr", 32'(a_eaddr), 5);
        corrupt = 0;
        pulse(0);
        chk("a_err_restart_error", 32'(a_error), 0);
        chk("a_err_restart_busy", 32'(a_busy), 1);
        push_a();

        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (a_wre && a_ad == 11'd7) begin
                seen = 1;
                break;
            end
        end
        chk("a_word7_seen", 32'(seen), 1);
        #1;
        a_rst_n = 0;
        #1;
        chk("a_midrst_wre", 32'(a_wre), 0);
        chk("a_midrst_cpu", 32'(a_cpu), 0);
        chk("a_midrst_done", 32'(a_done), 0);
        chk("a_midrst_err_addr", 32'(a_eaddr), 0);
        chk("a_midrst_ad", 32'(a_ad), 0);
        a_q.delete();
        @(negedge clk);
        a_rst_n = 1;
        push_a();
        run(0, k, bc);
        chk("a_reload_cycles", 32'(k), 56);
        chk("a_reload_done", 32'(a_done), 1);
        chk("a_reload_error", 32'(a_error), 0);
        for (int i = 0; i < 14; i++) chk("a_bram_reload", 32'(a_bram[i]), 32'(rom[i]));

        @(negedge clk);
        b_rst_n = 1;
        repeat (100) @(posedge clk);
        #1;
        chk("b_idle_writes", 32'(b_wr_cnt), 0);
        chk("b_idle_busy", 32'(b_busy), 0);
        chk("b_idle_done", 32'(b_done), 0);
        pulse(1);
        push_b();
        fork
            begin
                repeat (10) @(posedge clk);
                #2 b_start = 1;
                @(posedge clk);
                #2 b_start = 0;
            end
        join_none
        run(1, k, bc);
        chk("b_boot_cycles", 32'(k), 28);
        chk("b_done", 32'(b_done), 1);
        chk("b_cpu_rst_n", 32'(b_cpu), 1);
        chk("b_write_count", 32'(b_wr_cnt), 14);
        b_pc = 11'h7FF;
        #1;
        chk("b_mem_ad_pc", 32'(b_ad), 32'h7FF);
        for (int i = 0; i < 14; i++) chk("b_bram", 32'(b_bram[i]), 32'(rom[i]));

        @(negedge clk);
        c_rst_n = 1;
        for (int i = 0; i < 4; i++) c_q.push_back({2'(i), rom[i]});
        run(2, k, bc);
        chk("c_boot_cycles", 32'(k), 16);
        chk("c_done", 32'(c_done), 1);
        chk("c_error", 32'(c_error), 0);
        chk("c_write_count", 32'(c_wr_cnt), 4);
        for (int i = 0; i < 4; i++) chk("c_bram", 32'(c_bram[i]), 32'(rom[i]));
        repeat (10) @(posedge clk);
        #1;
        chk("c_no_wrap_writes", 32'(c_wr_cnt), 4);

        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
